motor_step_accumulator: RTL and testbench
=========================================

Name: motor_step_accumulator

Overview:
Parametrised successor to the Lab3 single-step position counter. It keeps a saturating up/down position count that moves once per qualified tick. Direction comes from a signed motor-speed word. Adds: a synchronous clock domain with a synchronised tick input, a proportional-step mode, a deadband, configurable limits, a priority load, and limit/step status. Sits between the PWM/motor-speed logic and the position display/feedback path.

Parameters:
WIDTH, 8, count width (unsigned)
SPEED_W, 8, motorSpeed width (two's complement)
CNT_MIN, 0, lower saturation limit
CNT_MAX, 255, upper saturation limit (CNT_MIN < CNT_MAX <= 2^WIDTH-1)
RESET_VAL, 0, count value after reset (CNT_MIN <= RESET_VAL <= CNT_MAX)
DEADBAND, 0, |motorSpeed| <= DEADBAND produces no movement
STEP_SHIFT, 4, proportional step = |motorSpeed| >> STEP_SHIFT

Ports:
clk  in  1  system clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
tickIn  in  1  slow/asynchronous update request (e.g. divided-clock enable); rising edge = one update
validIn  in  1  update qualifier (sensor valid); update ignored when 0
motorSpeed  in  SPEED_W  signed speed; sign = direction, magnitude used in mode 1
mode  in  1  0 = unit step (+/-1), 1 = proportional step
load  in  1  synchronous load request
loadValue  in  WIDTH  value for load
count  out  WIDTH  position count
atMin  out  1  count == CNT_MIN
atMax  out  1  count == CNT_MAX
stepDone  out  1  one-cycle pulse: a tick update was applied (including clamped/zero moves)

Behaviour:
- Reset (resetn=0, any time, asynchronous): count=RESET_VAL. Sync and edge registers=0. stepDone=0. atMin/atMax reflect RESET_VAL. Reset mid-update discards the pending tick.
- Tick path: tickIn -> 2-FF synchroniser -> edge register. The internal tickPulse is high for exactly one clk cycle per 0->1 transition of the synchronised tickIn. Count updates on the 3rd rising clk edge after tickIn is first sampled high. A tickIn held high produces exactly one update. A tickIn pulse shorter than one clk period may be missed; this is not an error.
- Update edge (tickPulse=1, load=0): validIn, motorSpeed and mode are sampled at this edge.
  - validIn=0: count holds; stepDone=0.
  - |motorSpeed| <= DEADBAND: count holds; stepDone=1.
  - mode=0: step = 1.
  - mode=1: step = max(1, |motorSpeed| >> STEP_SHIFT).
  - motorSpeed<0: count = max(CNT_MIN, count - step).
  - motorSpeed>0: count = min(CNT_MAX, count + step).
  - stepDone=1 on the edge the update is applied, cleared the following edge.
- Arithmetic: |motorSpeed| is computed in SPEED_W+1 bits, so the most negative value is -2^(SPEED_W-1) -> 2^(SPEED_W-1) with no overflow. Sum/difference is computed in max(WIDTH,SPEED_W)+2 bits signed before clamping. No wrap-around is permitted under any input.
- Load: load=1 at a rising edge sets count = clamp(loadValue, CNT_MIN, CNT_MAX). Load has priority over a coincident tickPulse; that tick is consumed and dropped, and stepDone=0.
- atMin/atMax are combinational compares of the count register; both are never high together.
- Holding at a limit: further moves toward that limit leave count unchanged, stepDone still pulses, and no glitch appears on count.

Test Plan:
- Reset: assert resetn=0 mid-run with count=37 -> count=0, atMin=1, atMax=0, stepDone=0 immediately (no clk edge needed).
- Unit mode: mode=0, validIn=1, motorSpeed=+5, 3 tickIn pulses from 0 -> count 1,2,3. Each update lands 3 clk edges after tickIn rises; one stepDone pulse per tick. tickIn held high 20 cycles -> exactly one increment.
- Proportional + saturation: load 250, mode=1, motorSpeed=+127 (step 7) -> count 255, atMax=1. A second tick -> count stays 255, stepDone=1.
- Negative extreme: load 10, mode=1, motorSpeed=-128 (step 8) -> 2; next tick -> 0 (clamped), atMin=1, no wrap to 250+.
- Gating/deadband: validIn=0 with tick -> count unchanged, stepDone=0. Rebuild with DEADBAND=3: motorSpeed=-3 -> unchanged with stepDone=1; motorSpeed=-4 -> decrement by 1.
- Load priority: load=1, loadValue=100 on the same edge as tickPulse with motorSpeed=+1 -> count=100 (not 101), stepDone=0. Rebuild with CNT_MAX=200: loadValue=230 -> count=200, atMax=1.

Source files
------------

// File: rtl/motor_step_accumulator.sv
// motor_step_accumulator
//   Saturating up/down position counter that moves once per qualified tick.
//   The direction comes from the sign of a signed motor-speed word. In unit
//   mode the count moves by one; in proportional mode it moves by the speed
//   magnitude shifted right, with a minimum of one. A deadband suppresses
//   movement for small speeds, a synchronous load has priority over a tick,
//   and the count saturates at CNT_MIN / CNT_MAX without wrapping.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   resetn      asynchronous active-low reset
//   tickIn      asynchronous update request; one update per rising edge
//   validIn     update qualifier; an update is ignored when low
//   motorSpeed  signed speed (sign = direction, magnitude used in mode 1)
//   mode        0 = unit step, 1 = proportional step
//   load        synchronous load request (priority over a tick)
//   loadValue   value to load, clamped into [CNT_MIN, CNT_MAX]
//   count       position count (registered)
//   atMin       count == CNT_MIN
//   atMax       count == CNT_MAX
//   stepDone    one-cycle pulse when a tick update is applied
module motor_step_accumulator #(
  parameter int WIDTH      = 8,
  parameter int SPEED_W    = 8,
  parameter int CNT_MIN    = 0,
  parameter int CNT_MAX    = 255,
  parameter int RESET_VAL  = 0,
  parameter int DEADBAND   = 0,
  parameter int STEP_SHIFT = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tickIn,
  input  logic               validIn,
  input  logic [SPEED_W-1:0] motorSpeed,
  input  logic               mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   loadValue,
  output logic [WIDTH-1:0]   count,
  output logic               atMin,
  output logic               atMax,
  output logic               stepDone
);

  // Signed working width for sum/difference: wide enough that neither the
  // count nor the largest step can overflow before clamping.
  localparam int SUM_W = ((WIDTH > SPEED_W) ? WIDTH : SPEED_W) + 2;

  localparam logic [WIDTH-1:0]        MIN_V = WIDTH'(CNT_MIN);
  localparam logic [WIDTH-1:0]        MAX_V = WIDTH'(CNT_MAX);
  localparam logic [WIDTH-1:0]        RST_V = WIDTH'(RESET_VAL);
  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(CNT_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(CNT_MAX);
  localparam logic [SPEED_W:0]        DB_V  = (SPEED_W + 1)'(DEADBAND);
  localparam logic [SPEED_W:0]        ONE_V = (SPEED_W + 1)'(1);

  logic                      sync1_r, sync2_r, edge_r;
  logic                      tick_pulse_s;
  logic [WIDTH-1:0]          count_r, count_nxt_s;
  logic                      step_done_r, step_done_nxt_s;
  logic [SPEED_W:0]          speed_ext_s, mag_s, shifted_s, step_s;
  logic signed [SUM_W-1:0]   count_ext_s, step_ext_s, load_ext_s;
  logic signed [SUM_W-1:0]   up_s, dn_s;
  logic [WIDTH-1:0]          up_clamp_s, dn_clamp_s, load_clamp_s;

  // Two-flop synchroniser plus edge register for the asynchronous tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= tickIn;
      sync2_r <= sync1_r;
      edge_r  <= sync2_r;
    end
  end

  // High for exactly one cycle per 0->1 transition of the synchronised tick.
  assign tick_pulse_s = sync2_r & ~edge_r;

  // Speed magnitude, step size and clamped candidate results.
  always_comb begin
    // One extra bit so the most negative speed has a representable magnitude.
    speed_ext_s = {motorSpeed[SPEED_W-1], motorSpeed};
    if (speed_ext_s[SPEED_W]) begin
      mag_s = ~speed_ext_s + ONE_V;
    end else begin
      mag_s = speed_ext_s;
    end

    shifted_s = mag_s >> STEP_SHIFT;
    if (!mode) begin
      step_s = ONE_V;
    end else if (shifted_s == {(SPEED_W + 1){1'b0}}) begin
      step_s = ONE_V;
    end else begin
      step_s = shifted_s;
    end

    count_ext_s = $signed({{(SUM_W - WIDTH){1'b0}}, count_r});
    step_ext_s  = $signed({{(SUM_W - SPEED_W - 1){1'b0}}, step_s});
    load_ext_s  = $signed({{(SUM_W - WIDTH){1'b0}}, loadValue});
    up_s        = count_ext_s + step_ext_s;
    dn_s        = count_ext_s - step_ext_s;

    if (up_s > MAX_S) begin
      up_clamp_s = MAX_V;
    end else begin
      up_clamp_s = up_s[WIDTH-1:0];
    end

    if (dn_s < MIN_S) begin
      dn_clamp_s = MIN_V;
    end else begin
      dn_clamp_s = dn_s[WIDTH-1:0];
    end

    if (load_ext_s < MIN_S) begin
      load_clamp_s = MIN_V;
    end else if (load_ext_s > MAX_S) begin
      load_clamp_s = MAX_V;
    end else begin
      load_clamp_s = loadValue;
    end
  end

  // Next count / stepDone: load wins over a coincident tick, which is dropped.
  always_comb begin
    count_nxt_s     = count_r;
    step_done_nxt_s = 1'b0;
    if (load) begin
      count_nxt_s     = load_clamp_s;
      step_done_nxt_s = 1'b0;
    end else if (tick_pulse_s) begin
      if (!validIn) begin
        count_nxt_s     = count_r;
        step_done_nxt_s = 1'b0;
      end else if (mag_s <= DB_V) begin
        // Inside the deadband: the update is applied as a zero move.
        count_nxt_s     = count_r;
        step_done_nxt_s = 1'b1;
      end else if (motorSpeed[SPEED_W-1]) begin
        count_nxt_s     = dn_clamp_s;
        step_done_nxt_s = 1'b1;
      end else begin
        count_nxt_s     = up_clamp_s;
        step_done_nxt_s = 1'b1;
      end
    end else begin
      count_nxt_s     = count_r;
      step_done_nxt_s = 1'b0;
    end
  end

  // Count and stepDone state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r     <= RST_V;
      step_done_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      step_done_r <= step_done_nxt_s;
    end
  end

  assign count    = count_r;
  assign stepDone = step_done_r;
  assign atMin    = (count_r == MIN_V);
  assign atMax    = (count_r == MAX_V);

endmodule

// File: tb/tb_motor_step_accumulator.sv
// Directed bench for motor_step_accumulator. Three instances share the same
// stimulus: defaults (m), DEADBAND=3 (d) and CNT_MAX=200 (c).
module tb_motor_step_accumulator;

  logic       clk;
  logic       resetn;
  logic       tickIn;
  logic       validIn;
  logic [7:0] motorSpeed;
  logic       mode;
  logic       load;
  logic [7:0] loadValue;

  logic [7:0] count_m, count_d, count_c;
  logic       atmin_m, atmax_m, done_m;
  logic       atmin_d, atmax_d, done_d;
  logic       atmin_c, atmax_c, done_c;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  motor_step_accumulator dut_m (
    .clk(clk), .resetn(resetn), .tickIn(tickIn), .validIn(validIn),
    .motorSpeed(motorSpeed), .mode(mode), .load(load), .loadValue(loadValue),
    .count(count_m), .atMin(atmin_m), .atMax(atmax_m), .stepDone(done_m)
  );

  motor_step_accumulator #(.DEADBAND(3)) dut_d (
    .clk(clk), .resetn(resetn), .tickIn(tickIn), .validIn(validIn),
    .motorSpeed(motorSpeed), .mode(mode), .load(load), .loadValue(loadValue),
    .count(count_d), .atMin(atmin_d), .atMax(atmax_d), .stepDone(done_d)
  );

  motor_step_accumulator #(.CNT_MAX(200)) dut_c (
    .clk(clk), .resetn(resetn), .tickIn(tickIn), .validIn(validIn),
    .motorSpeed(motorSpeed), .mode(mode), .load(load), .loadValue(loadValue),
    .count(count_c), .atMin(atmin_c), .atMax(atmax_c), .stepDone(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Raise tickIn and stop on the negedge after the 3rd rising edge.
  task automatic tick_rise();
    @(negedge clk) tickIn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Drop tickIn and let the synchroniser return to idle.
  task automatic settle();
    tickIn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    load      = 1'b1;
    loadValue = v;
    @(negedge clk);
    load      = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    tickIn     = 1'b0;
    validIn    = 1'b0;
    motorSpeed = 8'd0;
    mode       = 1'b0;
    load       = 1'b0;
    loadValue  = 8'd0;

    // Reset state
    #2;
    check("rst_count", 32'(count_m), 32'd0);
    check("rst_atmin", 32'(atmin_m), 32'd1);
    check("rst_atmax", 32'(atmax_m), 32'd0);
    check("rst_done",  32'(done_m),  32'd0);
    @(negedge clk) resetn = 1'b1;

    // Unit mode, first tick with latency check
    validIn    = 1'b1;
    motorSpeed = 8'd5;
    mode       = 1'b0;
    @(negedge clk) tickIn = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_before_3rd_edge", 32'(count_m), 32'd0);
    check("lat_done_early",      32'(done_m),  32'd0);
    @(negedge clk);
    check("unit_tick1", 32'(count_m), 32'd1);
    check("unit_done1", 32'(done_m),  32'd1);
    tickIn = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(done_m), 32'd0);
    repeat (3) @(negedge clk);
    tick_rise();
    check("unit_tick2", 32'(count_m), 32'd2);
    check("unit_done2", 32'(done_m),  32'd1);
    settle();
    tick_rise();
    check("unit_tick3", 32'(count_m), 32'd3);
    check("unit_done3", 32'(done_m),  32'd1);
    settle();

    // tickIn held high for 20 cycles: exactly one update
    pulses = 0;
    @(negedge clk) tickIn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_m) pulses++;
    end
    check("hold_count",  32'(count_m), 32'd4);
    check("hold_pulses", 32'(pulses),  32'd1);
    settle();

    // Proportional step with upper saturation
    do_load(8'd250);
    check("load_250", 32'(count_m), 32'd250);
    mode       = 1'b1;
    motorSpeed = 8'd127;
    tick_rise();
    check("prop_sat_count", 32'(count_m), 32'd255);
    check("prop_sat_atmax", 32'(atmax_m), 32'd1);
    settle();
    tick_rise();
    check("hold_max_count", 32'(count_m), 32'd255);
    check("hold_max_done",  32'(done_m),  32'd1);
    settle();

    // Most negative speed, lower saturation
    do_load(8'd10);
    motorSpeed = 8'h80;
    tick_rise();
    check("neg_ext_count", 32'(count_m), 32'd2);
    settle();
    tick_rise();
    check("neg_clamp_count", 32'(count_m), 32'd0);
    check("neg_clamp_atmin", 32'(atmin_m), 32'd1);
    check("neg_clamp_atmax", 32'(atmax_m), 32'd0);
    check("neg_clamp_done",  32'(done_m),  32'd1);
    settle();

    // validIn gating
    mode       = 1'b0;
    motorSpeed = 8'd5;
    validIn    = 1'b0;
    tick_rise();
    check("gated_count", 32'(count_m), 32'd0);
    check("gated_done",  32'(done_m),  32'd0);
    settle();
    validIn = 1'b1;

    // Deadband: DEADBAND=3 instance vs default instance
    do_load(8'd50);
    motorSpeed = 8'hFD;
    tick_rise();
    check("db3_in_band_count", 32'(count_d), 32'd50);
    check("db3_in_band_done",  32'(done_d),  32'd1);
    check("db0_minus3_count",  32'(count_m), 32'd49);
    settle();
    motorSpeed = 8'hFC;
    tick_rise();
    check("db3_out_band_count", 32'(count_d), 32'd49);
    check("db3_out_band_done",  32'(done_d),  32'd1);
    settle();

    // Load priority over a coincident tick pulse
    motorSpeed = 8'd1;
    @(negedge clk) tickIn = 1'b1;
    repeat (2) @(negedge clk);
    load      = 1'b1;
    loadValue = 8'd100;
    @(negedge clk);
    load = 1'b0;
    check("loadprio_count", 32'(count_m), 32'd100);
    check("loadprio_done",  32'(done_m),  32'd0);
    settle();
    check("loadprio_tick_dropped", 32'(count_m), 32'd100);

    // Load clamp with CNT_MAX=200
    do_load(8'd230);
    check("load_clamp_count", 32'(count_c), 32'd200);
    check("load_clamp_atmax", 32'(atmax_c), 32'd1);
    check("load_noclamp_count", 32'(count_m), 32'd230);

    // Asynchronous reset mid-run, pending tick discarded
    do_load(8'd37);
    check("pre_reset_count", 32'(count_m), 32'd37);
    @(negedge clk) tickIn = 1'b1;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_count", 32'(count_m), 32'd0);
    check("async_rst_atmin", 32'(atmin_m), 32'd1);
    check("async_rst_atmax", 32'(atmax_m), 32'd0);
    check("async_rst_done",  32'(done_m),  32'd0);
    tickIn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_discard_tick", 32'(count_m), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
